// File: rtl/relay_alu_pkg.sv
// Shared types for the relay ALU sequencer: ALU function codes and sequencer states.
package relay_alu_pkg;

    localparam int ALU_FN_W = 3;

    typedef enum logic [ALU_FN_W-1:0] {
        FN_ADD = 3'b000,
        FN_INC = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_NOT = 3'b101,
        FN_SHL = 3'b110,
        FN_CLR = 3'b111
    } alu_fn_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } seq_state_e;

endpackage

// File: rtl/relay_alu_comb.sv
// Purely combinational 8-function relay ALU evaluator producing result and carry.
module relay_alu_comb
    import relay_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_fn_e          fn,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // Function decode; arithmetic forms a (WIDTH+1)-bit sum whose top bit is the carry
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (fn)
            FN_ADD:  {carry, result} = {1'b0, b} + {1'b0, c};
            FN_INC:  {carry, result} = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
            FN_AND:  result = b & c;
            FN_OR:   result = b | c;
            FN_XOR:  result = b ^ c;
            FN_NOT:  result = ~b;
            FN_SHL: begin
                result = {b[WIDTH-2:0], b[WIDTH-1]};
                carry  = b[WIDTH-1];
            end
            FN_CLR:  result = {WIDTH{1'b0}};
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/relay_alu_sequencer.sv
// Relay ALU sequencer: request capture, relay settle delay, registered result/flags response.
// Build option RELAY_SETTLE_EN enables the SETTLE state and counter; without it results register on acceptance.
module relay_alu_sequencer
    import relay_alu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ALU_FN_W-1:0] fn,
    input  logic [WIDTH-1:0]    b_in,
    input  logic [WIDTH-1:0]    c_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    result,
    output logic                carry,
    output logic                zero,
    output logic                sign,
    output logic                busy
);

    if (WIDTH < 2 || WIDTH > 16 || SETTLE_CYCLES < 1) begin : g_bad_params
        $error("relay_alu_sequencer: WIDTH must be 2..16 and SETTLE_CYCLES >= 1");
    end

    seq_state_e       state_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             zero_r;
    logic             sign_r;
    logic             busy_r;

    alu_fn_e          alu_fn_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [WIDTH-1:0] alu_c_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_carry_s;
    logic             alu_zero_s;

`ifdef RELAY_SETTLE_EN
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [ALU_FN_W-1:0] fn_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    c_reg;
    logic [CNT_W-1:0]    cnt_r;

    assign alu_fn_s = alu_fn_e'(fn_reg);
    assign alu_b_s  = b_reg;
    assign alu_c_s  = c_reg;
`else
    // Without the settle model the ALU sees the request operands directly on the acceptance edge
    assign alu_fn_s = alu_fn_e'(fn);
    assign alu_b_s  = b_in;
    assign alu_c_s  = c_in;
`endif

    relay_alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu (
        .fn     (alu_fn_s),
        .b      (alu_b_s),
        .c      (alu_c_s),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    assign alu_zero_s = (alu_result_s == {WIDTH{1'b0}});

    // Sequencer state machine with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
`ifdef RELAY_SETTLE_EN
            fn_reg      <= {ALU_FN_W{1'b0}};
            b_reg       <= {WIDTH{1'b0}};
            c_reg       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        busy_r <= 1'b1;
`ifdef RELAY_SETTLE_EN
                        fn_reg  <= fn;
                        b_reg   <= b_in;
                        c_reg   <= c_in;
                        cnt_r   <= CNT_W'(SETTLE_CYCLES - 1);
                        state_r <= SETTLE;
`else
                        result_r    <= alu_result_s;
                        carry_r     <= alu_carry_s;
                        zero_r      <= alu_zero_s;
                        sign_r      <= alu_result_s[WIDTH-1];
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
`endif
                    end
                end
`ifdef RELAY_SETTLE_EN
                SETTLE: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        result_r    <= alu_result_s;
                        carry_r     <= alu_carry_s;
                        zero_r      <= alu_zero_s;
                        sign_r      <= alu_result_s[WIDTH-1];
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign result    = result_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign sign      = sign_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_relay_alu_sequencer.sv
// Directed, table-driven bench for relay_alu_sequencer (WIDTH=8, SETTLE_CYCLES=4), either RELAY_SETTLE_EN build.
module tb_relay_alu_sequencer;

    localparam int WIDTH         = 8;
    localparam int SETTLE_CYCLES = 4;
    // Rising edges up to and including the one that raises rsp_valid, counting the acceptance edge as 1
`ifdef RELAY_SETTLE_EN
    localparam int LAT = SETTLE_CYCLES + 1;
`else
    localparam int LAT = 1;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             req_valid = 1'b0;
    logic             rsp_ready = 1'b0;
    logic [2:0]       fn        = 3'b000;
    logic [WIDTH-1:0] b_in      = 8'h00;
    logic [WIDTH-1:0] c_in      = 8'h00;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             sign;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [2:0] fn;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] res;
        logic       cy;
        logic       z;
        logic       s;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    relay_alu_sequencer #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .fn        (fn),
        .b_in      (b_in),
        .c_in      (c_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .sign      (sign),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, let it be accepted, then wait (bounded) for the response and check it
    task automatic run_op(input vec_t v, input logic ready);
        int edges;
        check({v.name, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        fn        = v.fn;
        b_in      = v.b;
        c_in      = v.c;
        rsp_ready = ready;
        step();
        req_valid = 1'b0;
        fn        = ~v.fn;
        b_in      = ~v.b;
        c_in      = v.c ^ 8'h5A;
        check({v.name, "_busy"}, 32'(busy), 32'd1);
        edges = 1;
        while (!rsp_valid && edges < 100) begin
            step();
            edges++;
        end
        check({v.name, "_latency"}, 32'(edges), 32'(LAT));
        check({v.name, "_result"}, 32'(result), 32'(v.res));
        check({v.name, "_flags"}, {29'd0, carry, zero, sign}, {29'd0, v.cy, v.z, v.s});
    endtask

    initial begin
        logic ok;
        vec_t v;

        vecs[0]  = '{"add_carry", 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"and",       3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{"xor_zero",  3'b100, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"shl_wrap",  3'b110, 8'h81, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"not",       3'b101, 8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{"or",        3'b011, 8'h12, 8'h21, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"inc_wrap",  3'b001, 8'hFF, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{"inc_sign",  3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"clr",       3'b111, 8'h7E, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{"add_zero",  3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"shl_sign",  3'b110, 8'h40, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"add_plain", 3'b000, 8'h21, 8'h13, 8'h34, 1'b0, 1'b0, 1'b0};

        // Reset and idle state
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, carry, zero, sign}, 32'd0);

        // Table-driven functions, consumer always ready
        foreach (vecs[i]) begin
            run_op(vecs[i], 1'b1);
            step();
            check({vecs[i].name, "_idle_valid"}, 32'(rsp_valid), 32'd0);
            check({vecs[i].name, "_idle_busy"}, 32'(busy), 32'd0);
            check({vecs[i].name, "_held"}, 32'(result), 32'(vecs[i].res));
        end

        // Backpressure: response held while a competing request is offered
        v = '{"bp_and", 3'b010, 8'hF3, 8'h3F, 8'h33, 1'b0, 1'b0, 1'b0};
        run_op(v, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1;
            fn        = 3'b111;
            b_in      = 8'(k);
            c_in      = 8'hFF;
            step();
            if (!rsp_valid || req_ready || !busy || result !== 8'h33 || {carry, zero, sign} !== 3'b000)
                ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_result", 32'(result), 32'h33);
        v = '{"bp_next", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
        run_op(v, 1'b1);
        step();

        // Reset in the middle of an INC of all-ones
        v = '{"rst_inc", 3'b001, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        req_valid = 1'b1;
        fn        = v.fn;
        b_in      = v.b;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
`ifdef RELAY_SETTLE_EN
        check("midop_no_rsp_yet", 32'(rsp_valid), 32'd0);
`endif
        check("midop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_rst_valid", 32'(rsp_valid), 32'd0);
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_ready", 32'(req_ready), 32'd1);
        check("midop_rst_outs", {23'd0, result, carry, zero, sign}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rsp_valid || busy || !req_ready) ok = 1'b0;
        end
        check("midop_quiet_after", 32'(ok), 32'd1);

        // Service resumes normally after the aborted operation
        run_op(vecs[8], 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/relay_alu_sequencer.md
Name: relay_alu_sequencer

Overview:
- Controller that sequences the relay ALU for the relay computer model.
- Captures a function code and B/C operands through a valid/ready request.
- Models relay actuation with a programmable settle delay, then evaluates the 8-function ALU and returns result plus condition flags through a valid/ready response.
- Sits between the instruction sequencer (requester) and the data-bus / condition-register logic (consumer).

Parameters:
- WIDTH, 8: operand/result width in bits (legal range 2..16).
- SETTLE_CYCLES, 4: cycles the operands must be held before the result is sampled; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- fn  in  3  function code: 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 CLR.
- b_in  in  WIDTH  operand B.
- c_in  in  WIDTH  operand C.
- rsp_valid  out  1  result/flags valid.
- rsp_ready  in  1  consumer accepts the response.
- result  out  WIDTH  ALU result.
- carry  out  1  carry flag.
- zero  out  1  result == 0.
- sign  out  1  result[WIDTH-1].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, SETTLE, RESP. State register is reset asynchronously to IDLE.
- Reset values: rsp_valid=0, result=0, carry=0, zero=0, sign=0, busy=0. Internal registers b_reg, c_reg, fn_reg and settle counter are all cleared to 0.
- req_ready = (state==IDLE), combinational, so it reads 1 while in reset.
- IDLE:
  - On req_valid && req_ready, register fn, b_in and c_in.
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
  - With req_valid low, stay in IDLE.
- SETTLE:
  - The ALU evaluates combinationally from b_reg/c_reg/fn_reg.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, register result and flags, set rsp_valid=1 and go to RESP.
  - Request inputs are ignored while in SETTLE.
- RESP:
  - Hold result, flags and rsp_valid stable while rsp_ready=0.
  - On rsp_ready=1, clear rsp_valid and go to IDLE on the next edge. result and flags keep their last values.
  - No same-cycle back-to-back: a new request can be accepted at the earliest one cycle after the response handshake.
- Latency: rsp_valid rises exactly SETTLE_CYCLES+1 rising edges after the acceptance edge.
- Arithmetic, with W = WIDTH:
  - ADD: {carry,result} = b+c, (W+1)-bit sum.
  - INC: {carry,result} = b+1. Operand C is ignored.
  - AND / OR / XOR: bitwise b op c; carry=0.
  - NOT: ~b; carry=0.
  - SHL: rotate left, result={b[W-2:0],b[W-1]}; carry=b[W-1].
  - CLR: result=0; carry=0.
- zero and sign are always derived from the registered result.
- Wrap-around: ADD/INC overflow wraps modulo 2^W with carry=1, e.g. INC of all-ones gives result 0, zero=1, carry=1.
- Reset mid-operation (SETTLE or RESP): return to IDLE asynchronously, drop the pending operation, clear all outputs. No response is emitted after reset.

Optional Feature:
- Macro: RELAY_SETTLE_EN.
- Defined: the SETTLE state and counter exist, with timing as above.
- Undefined: the counter and the SETTLE state are removed. Acceptance goes straight to RESP with the result registered on the acceptance edge, so rsp_valid rises 1 edge after acceptance. SETTLE_CYCLES is ignored. Function and flag behaviour are identical.

Decomposition:
- Package relay_alu_pkg holds:
  - enum alu_fn_e for the 3-bit function codes;
  - enum seq_state_e {IDLE, SETTLE, RESP};
  - constant ALU_FN_W=3.
- One sub-module, relay_alu_comb: purely combinational WIDTH-bit function evaluator with inputs fn, b, c and outputs result, carry. It is instantiated once by the sequencer; the sequencer derives zero and sign.

Test Plan:
- Reset/idle: assert rst_n=0, release -> req_ready=1, busy=0, rsp_valid=0, result=0, all flags 0.
- ADD carry: WIDTH=8, SETTLE_CYCLES=4, fn=ADD, b=0xF0, c=0x20, rsp_ready=1 -> rsp_valid on 5th edge after accept; result=0x10, carry=1, zero=0, sign=0.
- Logic and rotate:
  - AND b=0xCC c=0xAA -> 0x88, sign=1.
  - XOR b=0x55 c=0x55 -> 0x00, zero=1.
  - SHL b=0x81 -> 0x03, carry=1.
  - NOT b=0x0F -> 0xF0, sign=1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> result/flags stable, req_ready=0, a new req_valid is not accepted. Raise rsp_ready -> IDLE next cycle, next request accepted one cycle later.
- Reset mid-op: pulse rst_n low two cycles after acceptance of INC b=0xFF -> rsp_valid never asserts, outputs 0, IDLE after release.
- Macro off (RELAY_SETTLE_EN undefined): CLR with b=0x7E -> rsp_valid 1 edge after accept, result=0, zero=1, carry=0.
